// File: rtl/mem_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// mem_arbiter_if : requester / RAM bus bundle for the mem_arbiter byte sequencer
// Rev 1.0
// ============================================================================
interface mem_arbiter_if #(
   parameter int ADDR_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_flush;
   logic              if_done;
   logic [31:0]       if_inst;
   logic              mem_req;
   logic              mem_we;
   logic [1:0]        mem_len;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              mem_done;
   logic [31:0]       mem_rdata;
   logic [7:0]        ram_din;
   logic [7:0]        ram_dout;
   logic [ADDR_W-1:0] ram_a;
   logic              ram_wr;
   logic              io_buffer_full;
   logic              busy;

   modport slave (
      input  if_req, if_addr, if_flush, mem_req, mem_we, mem_len, mem_addr, mem_wdata,
             ram_din, io_buffer_full,
      output if_done, if_inst, mem_done, mem_rdata, ram_dout, ram_a, ram_wr, busy
   );

   modport master (
      output if_req, if_addr, if_flush, mem_req, mem_we, mem_len, mem_addr, mem_wdata,
             ram_din, io_buffer_full,
      input  if_done, if_inst, mem_done, mem_rdata, ram_dout, ram_a, ram_wr, busy
   );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// mem_arbiter : shares the byte-wide RAM port between IF and MEM, serialising
//               little-endian byte transfers. Option: MEM_ARBITER_IO_STALL_EN.
// Rev 1.0
// ============================================================================
module mem_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int IO_ADDR_BIT = 17
) (
   input  wire logic     clk_in,
   input  wire logic     rst_in,
   mem_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic              src_if_q, src_if_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [2:0]        n_q, n_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       asm_q, asm_d;
   logic [ADDR_W-1:0] ram_a_q, ram_a_d;
   logic [7:0]        ram_dout_q, ram_dout_d;
   logic              ram_wr_q, ram_wr_d;
   logic              if_done_q, if_done_d;
   logic [31:0]       if_inst_q, if_inst_d;
   logic              mem_done_q, mem_done_d;
   logic [31:0]       mem_rdata_q, mem_rdata_d;
   logic              busy_q, busy_d;

   logic              w_acc_stall;
   logic              w_cur_stall;
   logic [1:0]        w_cap_idx;
   logic [2:0]        w_rd_next;
   logic [2:0]        w_wr_k;
   logic [31:0]       w_asm_next;

   function automatic logic [2:0] len_to_n(input logic [1:0] len);
      case (len)
         2'd0:    return 3'd1;
         2'd1:    return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

`ifdef MEM_ARBITER_IO_STALL_EN
   assign w_acc_stall = (bus.mem_addr[IO_ADDR_BIT -: 2] == 2'b11) && bus.io_buffer_full;
   assign w_cur_stall = (addr_q[IO_ADDR_BIT -: 2] == 2'b11) && bus.io_buffer_full;
`else
   logic w_unused_io;
   assign w_acc_stall = 1'b0;
   assign w_cur_stall = 1'b0;
   assign w_unused_io = bus.io_buffer_full | (IO_ADDR_BIT == 0);
`endif

   // Read byte k arrives one edge after its address is sampled, hence the lag of one.
   assign w_cap_idx = cnt_q[1:0] - 2'd1;
   assign w_rd_next = cnt_q + 3'd1;
   // A stalled write leaves ram_wr low, so the same byte index is offered again.
   assign w_wr_k    = ram_wr_q ? cnt_q + 3'd1 : cnt_q;

   always_comb begin
      w_asm_next = asm_q;
      if (cnt_q != 3'd0) begin
         w_asm_next[{w_cap_idx, 3'b000} +: 8] = bus.ram_din;
      end
   end

   always_comb begin
      state_d     = state_q;
      src_if_d    = src_if_q;
      cnt_d       = cnt_q;
      n_d         = n_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      asm_d       = asm_q;
      ram_a_d     = ram_a_q;
      ram_dout_d  = ram_dout_q;
      ram_wr_d    = ram_wr_q;
      if_inst_d   = if_inst_q;
      mem_rdata_d = mem_rdata_q;
      if_done_d   = 1'b0;
      mem_done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.mem_req) begin
               src_if_d = 1'b0;
               addr_d   = bus.mem_addr;
               wdata_d  = bus.mem_wdata;
               n_d      = len_to_n(bus.mem_len);
               asm_d    = '0;
               cnt_d    = '0;
               ram_a_d  = bus.mem_addr;
               if (bus.mem_we) begin
                  state_d    = S_WRITE;
                  ram_dout_d = bus.mem_wdata[7:0];
                  ram_wr_d   = !w_acc_stall;
               end else begin
                  state_d  = S_READ;
                  ram_wr_d = 1'b0;
               end
            end else if (bus.if_req && !bus.if_flush) begin
               src_if_d = 1'b1;
               addr_d   = bus.if_addr;
               n_d      = 3'd4;
               asm_d    = '0;
               cnt_d    = '0;
               ram_a_d  = bus.if_addr;
               ram_wr_d = 1'b0;
               state_d  = S_READ;
            end
         end
         S_READ: begin
            if (src_if_q && bus.if_flush) begin
               state_d = S_IDLE;
               ram_a_d = '0;
               cnt_d   = '0;
            end else begin
               asm_d   = w_asm_next;
               cnt_d   = w_rd_next;
               ram_a_d = (w_rd_next < n_q) ? addr_q + ADDR_W'(w_rd_next) : '0;
               if (cnt_q == n_q) begin
                  state_d = S_DONE;
                  if (src_if_q) begin
                     if_inst_d = w_asm_next;
                     if_done_d = 1'b1;
                  end else begin
                     mem_rdata_d = w_asm_next;
                     mem_done_d  = 1'b1;
                  end
               end
            end
         end
         S_WRITE: begin
            if (w_wr_k == n_q) begin
               state_d    = S_DONE;
               ram_wr_d   = 1'b0;
               ram_a_d    = '0;
               ram_dout_d = '0;
               mem_done_d = 1'b1;
            end else begin
               cnt_d      = w_wr_k;
               ram_a_d    = addr_q + ADDR_W'(w_wr_k);
               ram_dout_d = wdata_q[{w_wr_k[1:0], 3'b000} +: 8];
               ram_wr_d   = !w_cur_stall;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            ram_a_d = '0;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q     <= S_IDLE;
         src_if_q    <= 1'b0;
         cnt_q       <= '0;
         n_q         <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         asm_q       <= '0;
         ram_a_q     <= '0;
         ram_dout_q  <= '0;
         ram_wr_q    <= 1'b0;
         if_done_q   <= 1'b0;
         if_inst_q   <= '0;
         mem_done_q  <= 1'b0;
         mem_rdata_q <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         src_if_q    <= src_if_d;
         cnt_q       <= cnt_d;
         n_q         <= n_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         asm_q       <= asm_d;
         ram_a_q     <= ram_a_d;
         ram_dout_q  <= ram_dout_d;
         ram_wr_q    <= ram_wr_d;
         if_done_q   <= if_done_d;
         if_inst_q   <= if_inst_d;
         mem_done_q  <= mem_done_d;
         mem_rdata_q <= mem_rdata_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.if_done   = if_done_q;
   assign bus.if_inst   = if_inst_q;
   assign bus.mem_done  = mem_done_q;
   assign bus.mem_rdata = mem_rdata_q;
   assign bus.ram_dout  = ram_dout_q;
   assign bus.ram_a     = ram_a_q;
   assign bus.ram_wr    = ram_wr_q;
   assign bus.busy      = busy_q;
endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_mem_arbiter : randomized bench with a byte-memory reference model
// Rev 1.0
// ============================================================================
module tb_mem_arbiter;
   logic clk_in = 1'b0;
   logic rst_in = 1'b0;
   always #5 clk_in = ~clk_in;

   mem_arbiter_if #(.ADDR_W(32)) bus ();

   mem_arbiter #(
      .ADDR_W      (32),
      .IO_ADDR_BIT (17)
   ) dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .bus    (bus.slave)
   );

   int n_chk  = 0;
   int n_fail = 0;

   logic [7:0] ram_env [logic [31:0]];
   logic [7:0] shadow  [logic [31:0]];

   function automatic logic [7:0] init_byte(input logic [31:0] a);
      return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'hA5;
   endfunction

   function automatic logic [7:0] env_rd(input logic [31:0] a);
      if (ram_env.exists(a)) return ram_env[a];
      return init_byte(a);
   endfunction

   function automatic logic [7:0] shd_rd(input logic [31:0] a);
      if (shadow.exists(a)) return shadow[a];
      return init_byte(a);
   endfunction

   // Byte RAM: address sampled at the edge, data valid the following cycle.
   always @(posedge clk_in) begin
      if (bus.ram_wr) ram_env[bus.ram_a] = bus.ram_dout;
      bus.ram_din <= env_rd(bus.ram_a);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk_in);
      #1;
   endtask

   task automatic preset(input logic [31:0] a, input logic [7:0] b);
      ram_env[a] = b;
      shadow[a]  = b;
   endtask

   // One transaction accepted at the next edge; reads finish N+1 edges later, writes N.
   task automatic do_txn(input bit is_if, input bit we, input logic [1:0] len,
                         input logic [31:0] addr, input logic [31:0] wdata);
      int n;
      int last;
      logic [31:0] exp;
      logic done_o;
      logic other_o;
      n    = is_if ? 4 : (len == 2'd0 ? 1 : (len == 2'd1 ? 2 : 4));
      last = we ? n : n + 1;
      exp  = '0;
      for (int j = 0; j < n; j++) exp |= 32'(shd_rd(addr + 32'(j))) << (8 * j);
      if (is_if) begin
         bus.if_req  = 1'b1;
         bus.if_addr = addr;
      end else begin
         bus.mem_req   = 1'b1;
         bus.mem_we    = we;
         bus.mem_len   = len;
         bus.mem_addr  = addr;
         bus.mem_wdata = wdata;
      end
      for (int k = 0; k <= last; k++) begin
         tick;
         if (!is_if && !bus.if_req) bus.if_flush = 1'($urandom_range(0, 1));
         done_o  = is_if ? bus.if_done  : bus.mem_done;
         other_o = is_if ? bus.mem_done : bus.if_done;
         check_eq("busy", 32'(bus.busy), 32'd1);
         check_eq("done", 32'(done_o), 32'(k == last));
         check_eq("other_done", 32'(other_o), 32'd0);
         if (k < n) begin
            check_eq("ram_a", bus.ram_a, addr + 32'(k));
            check_eq("ram_wr", 32'(bus.ram_wr), 32'(we));
            if (we) check_eq("ram_dout", 32'(bus.ram_dout), 32'(wdata[8*k +: 8]));
         end
         if (k == last && !we) check_eq("rdata", is_if ? bus.if_inst : bus.mem_rdata, exp);
      end
      if (is_if) bus.if_req = 1'b0;
      else       bus.mem_req = 1'b0;
      bus.if_flush = 1'b0;
      tick;
      check_eq("idle_busy", 32'(bus.busy), 32'd0);
      check_eq("done_fall", 32'(is_if ? bus.if_done : bus.mem_done), 32'd0);
      if (!we) check_eq("rdata_hold", is_if ? bus.if_inst : bus.mem_rdata, exp);
      if (we) for (int j = 0; j < n; j++) shadow[addr + 32'(j)] = wdata[8*j +: 8];
   endtask

   logic [31:0] ra;
   int          sel;

   initial begin
      bus.if_req = 0; bus.if_addr = 0; bus.if_flush = 0;
      bus.mem_req = 0; bus.mem_we = 0; bus.mem_len = 0; bus.mem_addr = 0; bus.mem_wdata = 0;
      bus.io_buffer_full = 0;

      tick; tick;
      check_eq("rst_busy", 32'(bus.busy), 32'd0);
      check_eq("rst_ram_a", bus.ram_a, 32'd0);
      check_eq("rst_ram_wr", 32'(bus.ram_wr), 32'd0);
      check_eq("rst_if_done", 32'(bus.if_done), 32'd0);
      check_eq("rst_mem_done", 32'(bus.mem_done), 32'd0);
      check_eq("rst_if_inst", bus.if_inst, 32'd0);
      rst_in = 1'b1;
      tick;

      preset(32'h100, 8'h13); preset(32'h101, 8'h00); preset(32'h102, 8'h00); preset(32'h103, 8'h00);
      do_txn(1'b1, 1'b0, 2'd0, 32'h100, 32'h0);
      check_eq("if_inst_nop", bus.if_inst, 32'h0000_0013);

      // Simultaneous requests: MEM wins, IF follows once the arbiter is idle again.
      preset(32'h2000, 8'hF0);
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h104;
      do_txn(1'b0, 1'b0, 2'd0, 32'h2000, 32'h0);
      check_eq("mem_byte_f0", bus.mem_rdata, 32'h0000_00F0);
      do_txn(1'b1, 1'b0, 2'd0, 32'h104, 32'h0);

      do_txn(1'b0, 1'b1, 2'd3, 32'h1FFFC, 32'hAABB_CCDD);
      do_txn(1'b0, 1'b0, 2'd3, 32'h1FFFC, 32'h0);
      check_eq("store_readback", bus.mem_rdata, 32'hAABB_CCDD);

      // Flush an in-flight fetch after E2 with a load pending.
      bus.if_req = 1'b1; bus.if_addr = 32'h200;
      tick;
      check_eq("flush_busy_e0", 32'(bus.busy), 32'd1);
      tick; tick;
      bus.if_flush = 1'b1; bus.if_req = 1'b0;
      bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_len = 2'd0; bus.mem_addr = 32'h2000;
      tick;
      check_eq("flush_idle", 32'(bus.busy), 32'd0);
      check_eq("flush_no_done", 32'(bus.if_done), 32'd0);
      check_eq("flush_ram_a", bus.ram_a, 32'd0);
      bus.if_flush = 1'b0;
      do_txn(1'b0, 1'b0, 2'd0, 32'h2000, 32'h0);

      do_txn(1'b0, 1'b0, 2'd1, 32'hFFFF_FFFF, 32'h0);
      check_eq("wrap_rdata", bus.mem_rdata, {16'h0, shd_rd(32'h0), shd_rd(32'hFFFF_FFFF)});

      // Fetch request with a same-cycle flush is ignored in IDLE.
      bus.if_req = 1'b1; bus.if_addr = 32'h300; bus.if_flush = 1'b1;
      tick;
      check_eq("idle_flush_ignored", 32'(bus.busy), 32'd0);
      bus.if_flush = 1'b0;
      do_txn(1'b1, 1'b0, 2'd0, 32'h300, 32'h0);

      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 2))
            0:       ra = $urandom;
            1:       ra = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            default: ra = 32'h1000 + 32'($urandom_range(0, 15));
         endcase
         sel = int'($urandom_range(0, 2));
         case (sel)
            0:       do_txn(1'b1, 1'b0, 2'd0, ra, 32'h0);
            1:       do_txn(1'b0, 1'b0, 2'($urandom_range(0, 3)), ra, 32'h0);
            default: do_txn(1'b0, 1'b1, 2'($urandom_range(0, 3)), ra, $urandom);
         endcase
      end

`ifdef MEM_ARBITER_IO_STALL_EN
      bus.io_buffer_full = 1'b1;
      bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_len = 2'd0;
      bus.mem_addr = 32'h30000; bus.mem_wdata = 32'h0000_005A;
      for (int k = 0; k < 3; k++) begin
         tick;
         check_eq("stall_wr_low", 32'(bus.ram_wr), 32'd0);
      end
      bus.io_buffer_full = 1'b0;
      tick;
      check_eq("stall_wr_high", 32'(bus.ram_wr), 32'd1);
      check_eq("stall_dout", 32'(bus.ram_dout), 32'h5A);
      check_eq("stall_no_done", 32'(bus.mem_done), 32'd0);
      tick;
      check_eq("stall_done", 32'(bus.mem_done), 32'd1);
      bus.mem_req = 1'b0;
      shadow[32'h30000] = 8'h5A;
      tick;
`endif

      // Asynchronous reset in the middle of a word store.
      bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_len = 2'd3;
      bus.mem_addr = 32'h500; bus.mem_wdata = 32'h1234_5678;
      tick; tick;
      check_eq("pre_rst_wr", 32'(bus.ram_wr), 32'd1);
      rst_in = 1'b0;
      bus.mem_req = 1'b0;
      #1;
      check_eq("async_rst_wr", 32'(bus.ram_wr), 32'd0);
      check_eq("async_rst_a", bus.ram_a, 32'd0);
      check_eq("async_rst_dout", 32'(bus.ram_dout), 32'd0);
      check_eq("async_rst_busy", 32'(bus.busy), 32'd0);
      check_eq("async_rst_rdata", bus.mem_rdata, 32'd0);
      tick; tick;
      rst_in = 1'b1;
      tick;
      check_eq("rst_no_done", 32'(bus.mem_done), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
